// File: rtl/opt_pkg.sv
// Shared definitions for the continuation-value evaluator.
// Holds default pass size and fixed-point format, datapath widths, the
// controller state encoding and the fitted-value saturation helper.
package opt_pkg;

  localparam int N_PATHS_DFLT = 1024;  // paths per evaluation pass
  localparam int FRAC_DFLT    = 8;     // fractional bits of the coefficients

  localparam int COEF_W = 18;  // signed regression coefficient
  localparam int DATA_W = 16;  // unsigned path state / cashflow fields
  localparam int SQ_W   = 32;  // x*x
  localparam int SUM_W  = 52;  // full-precision polynomial sum
  localparam int FIT_W  = 24;  // saturated fitted value on the output
  localparam int CNT_W  = 11;  // wide enough to hold N_PATHS itself

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DRAIN   = 2'd2,
    DONE_ST = 2'd3
  } state_e;

  // Clamp a full-precision fitted value into the signed 24-bit output range.
  function automatic logic signed [FIT_W-1:0] sat_fit(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    hi = 52'sd8388607;
    lo = -52'sd8388608;
    if (v > hi) begin
      return 24'sh7FFFFF;
    end else if (v < lo) begin
      return 24'sh800000;
    end else begin
      return v[FIT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/cont_eval_if.sv
// Bus bundle between a pass driver and cont_eval.
// master: drives start/coefficients, the input sample handshake and out_ready.
// slave : returns in_ready, the output handshake/fields, ex_count, busy, done.
interface cont_eval_if;
  import opt_pkg::*;

  logic                     start;
  logic signed [COEF_W-1:0] coef_b0;
  logic signed [COEF_W-1:0] coef_b1;
  logic signed [COEF_W-1:0] coef_b2;
  logic                     in_valid;
  logic                     in_ready;
  logic        [DATA_W-1:0] x_in;
  logic        [DATA_W-1:0] ex_in;
  logic        [DATA_W-1:0] cf_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [FIT_W-1:0]  fit_out;
  logic                     exercise;
  logic        [DATA_W-1:0] value_out;
  logic        [CNT_W-1:0]  ex_count;
  logic                     busy;
  logic                     done;

  modport master (
    output start, coef_b0, coef_b1, coef_b2, in_valid, x_in, ex_in, cf_in, out_ready,
    input  in_ready, out_valid, fit_out, exercise, value_out, ex_count, busy, done
  );

  modport slave (
    input  start, coef_b0, coef_b1, coef_b2, in_valid, x_in, ex_in, cf_in, out_ready,
    output in_ready, out_valid, fit_out, exercise, value_out, ex_count, busy, done
  );

endinterface

// File: rtl/poly_eval_pipe.sv
// Two-stage stallable polynomial datapath.
// Stage 1 registers the sample and x*x; stage 2 evaluates
// b0 + b1*x + b2*x^2 at full width, scales by FRAC, makes the exercise
// decision and registers the output fields. Both stages advance only on adv_i.
// Ports: clk/rst, adv_i (pipeline enable), in_fire_i (sample accepted),
// x_i/ex_i/cf_i (sample), b0_i..b2_i (pass coefficients),
// out_valid_o/fit_o/exercise_o/value_o (registered result).
module poly_eval_pipe
  import opt_pkg::*;
#(
  parameter int FRAC = FRAC_DFLT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adv_i,
  input  logic                     in_fire_i,
  input  logic        [DATA_W-1:0] x_i,
  input  logic        [DATA_W-1:0] ex_i,
  input  logic        [DATA_W-1:0] cf_i,
  input  logic signed [COEF_W-1:0] b0_i,
  input  logic signed [COEF_W-1:0] b1_i,
  input  logic signed [COEF_W-1:0] b2_i,
  output logic                     out_valid_o,
  output logic signed [FIT_W-1:0]  fit_o,
  output logic                     exercise_o,
  output logic        [DATA_W-1:0] value_o
);

  logic              s1_valid_q;
  logic [DATA_W-1:0] x_q;
  logic [SQ_W-1:0]   x2_q;
  logic [DATA_W-1:0] ex_q;
  logic [DATA_W-1:0] cf_q;

  logic                     out_valid_q;
  logic signed [FIT_W-1:0]  fit_q;
  logic                     exercise_q;
  logic        [DATA_W-1:0] value_q;

  logic signed [SUM_W-1:0] b0_ext_s;
  logic signed [SUM_W-1:0] b1_ext_s;
  logic signed [SUM_W-1:0] b2_ext_s;
  logic signed [SUM_W-1:0] x_ext_s;
  logic signed [SUM_W-1:0] x2_ext_s;
  logic signed [SUM_W-1:0] ex_ext_s;
  logic signed [SUM_W-1:0] sum_s;
  logic signed [SUM_W-1:0] fit_s;
  logic                    exercise_s;

  // Stage 1: capture the accepted sample and its square.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      x_q        <= 16'd0;
      x2_q       <= 32'd0;
      ex_q       <= 16'd0;
      cf_q       <= 16'd0;
    end else if (adv_i) begin
      s1_valid_q <= in_fire_i;
      if (in_fire_i) begin
        x_q  <= x_i;
        x2_q <= {{(SQ_W-DATA_W){1'b0}}, x_i} * {{(SQ_W-DATA_W){1'b0}}, x_i};
        ex_q <= ex_i;
        cf_q <= cf_i;
      end
    end
  end

  // Coefficients sign-extend; x, x^2 and ex are unsigned so they zero-extend
  // into the signed domain. 52 bits holds every product and the sum exactly.
  assign b0_ext_s = {{(SUM_W-COEF_W){b0_i[COEF_W-1]}}, b0_i};
  assign b1_ext_s = {{(SUM_W-COEF_W){b1_i[COEF_W-1]}}, b1_i};
  assign b2_ext_s = {{(SUM_W-COEF_W){b2_i[COEF_W-1]}}, b2_i};
  assign x_ext_s  = $signed({{(SUM_W-DATA_W){1'b0}}, x_q});
  assign x2_ext_s = $signed({{(SUM_W-SQ_W){1'b0}}, x2_q});
  assign ex_ext_s = $signed({{(SUM_W-DATA_W){1'b0}}, ex_q});

  assign sum_s = b0_ext_s + (b1_ext_s * x_ext_s) + (b2_ext_s * x2_ext_s);
  assign fit_s = sum_s >>> FRAC;

  // Compare against the unsaturated fit so a clamped output never flips the decision.
  assign exercise_s = (ex_q != 16'd0) && (ex_ext_s > fit_s);

  // Stage 2: register the result; fields only change when a new sample lands,
  // so the last result stays visible after the pass completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      fit_q       <= 24'sd0;
      exercise_q  <= 1'b0;
      value_q     <= 16'd0;
    end else if (adv_i) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        fit_q      <= sat_fit(fit_s);
        exercise_q <= exercise_s;
        value_q    <= exercise_s ? ex_q : cf_q;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign fit_o       = fit_q;
  assign exercise_o  = exercise_q;
  assign value_o     = value_q;

endmodule

// File: rtl/cont_eval.sv
// Continuation-value evaluator: runs one pass of N_PATHS samples through the
// polynomial datapath, counting accepted inputs, delivered outputs and
// exercised paths.
// Ports: clk (rising edge), rst (synchronous, active-high),
// bus (cont_eval_if.slave: start/coefficients, in/out handshakes, result
// fields, ex_count, busy, done).
module cont_eval
  import opt_pkg::*;
#(
  parameter int N_PATHS = N_PATHS_DFLT,
  parameter int FRAC    = FRAC_DFLT
) (
  input logic        clk,
  input logic        rst,
  cont_eval_if.slave bus
);

  localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N_PATHS);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e                   state_q;
  logic        [CNT_W-1:0]  in_cnt_q;
  logic        [CNT_W-1:0]  out_cnt_q;
  logic        [CNT_W-1:0]  ex_cnt_q;
  logic signed [COEF_W-1:0] b0_q;
  logic signed [COEF_W-1:0] b1_q;
  logic signed [COEF_W-1:0] b2_q;
  logic                     busy_q;
  logic                     done_q;

  logic                     adv_s;
  logic                     in_ready_s;
  logic                     in_fire_s;
  logic                     out_fire_s;
  logic                     out_valid_s;
  logic                     exercise_s;
  logic signed [FIT_W-1:0]  fit_s;
  logic        [DATA_W-1:0] value_s;

  // The whole pipeline moves only when the output register can hand off.
  assign adv_s      = !out_valid_s || bus.out_ready;
  assign in_ready_s = (state_q == RUN) && (in_cnt_q < N_CNT) && adv_s;
  assign in_fire_s  = bus.in_valid && in_ready_s;
  assign out_fire_s = out_valid_s && bus.out_ready;

  poly_eval_pipe #(
    .FRAC (FRAC)
  ) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .adv_i       (adv_s),
    .in_fire_i   (in_fire_s),
    .x_i         (bus.x_in),
    .ex_i        (bus.ex_in),
    .cf_i        (bus.cf_in),
    .b0_i        (b0_q),
    .b1_i        (b1_q),
    .b2_i        (b2_q),
    .out_valid_o (out_valid_s),
    .fit_o       (fit_s),
    .exercise_o  (exercise_s),
    .value_o     (value_s)
  );

  // Pass controller: state, counters, coefficient latch, busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_cnt_q  <= {CNT_W{1'b0}};
      out_cnt_q <= {CNT_W{1'b0}};
      ex_cnt_q  <= {CNT_W{1'b0}};
      b0_q      <= {COEF_W{1'b0}};
      b1_q      <= {COEF_W{1'b0}};
      b2_q      <= {COEF_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (in_fire_s) begin
        in_cnt_q <= in_cnt_q + CNT_ONE;
      end
      if (out_fire_s) begin
        out_cnt_q <= out_cnt_q + CNT_ONE;
        if (exercise_s) begin
          ex_cnt_q <= ex_cnt_q + CNT_ONE;
        end
      end
      case (state_q)
        IDLE, DONE_ST: begin
          // Coefficients only load here, so they stay fixed for the whole pass.
          if (bus.start) begin
            state_q   <= RUN;
            b0_q      <= bus.coef_b0;
            b1_q      <= bus.coef_b1;
            b2_q      <= bus.coef_b2;
            in_cnt_q  <= {CNT_W{1'b0}};
            out_cnt_q <= {CNT_W{1'b0}};
            ex_cnt_q  <= {CNT_W{1'b0}};
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          if (in_cnt_q == N_CNT) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_cnt_q == N_CNT) begin
            state_q <= DONE_ST;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.fit_out   = fit_s;
  assign bus.exercise  = exercise_s;
  assign bus.value_out = value_s;
  assign bus.ex_count  = ex_cnt_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: doc/cont_eval.md
CONT_EVAL -- requirements
Module: cont_eval

Interface
REQ-001 SHALL have parameter N_PATHS, default 1024: paths per evaluation pass.
REQ-002 SHALL have parameter FRAC, default 8: fractional bits of coefficients.
REQ-003 SHALL have clk  input  1: the single clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have start  input  1: begin a pass; latches coefficients.
REQ-006 SHALL have coef_b0, coef_b1, coef_b2  input  18 each: signed regression coefficients, Q(18-FRAC).FRAC.
REQ-007 SHALL have in_valid  input  1, in_ready  output  1: input handshake.
REQ-008 SHALL have x_in  input  16: unsigned path state.
REQ-009 SHALL have ex_in  input  16: unsigned immediate exercise value.
REQ-010 SHALL have cf_in  input  16: unsigned discounted continuation cashflow.
REQ-011 SHALL have out_valid  output  1, out_ready  input  1: output handshake.
REQ-012 SHALL have fit_out  output  24: signed fitted continuation value, saturated.
REQ-013 SHALL have exercise  output  1: path exercised.
REQ-014 SHALL have value_out  output  16: selected path value.
REQ-015 SHALL have ex_count  output  11: exercised paths this pass.
REQ-016 SHALL have busy  output  1 and done  output  1 (one-cycle pulse).

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE_ST.
- IDLE/DONE_ST + start -> RUN; latch b0..b2; clear in_cnt, out_cnt, ex_count.
- RUN -> DRAIN when in_cnt reaches N_PATHS.
- DRAIN -> DONE_ST when out_cnt reaches N_PATHS; done=1 for exactly that transition cycle.
REQ-018 SHALL ignore start in RUN and DRAIN; coefficients SHALL NOT change mid-pass.
REQ-019 SHALL drive in_ready = (state==RUN) && (in_cnt<N_PATHS) && adv, where adv = !out_valid || out_ready.
REQ-020 SHALL accept a sample only on in_valid && in_ready.
REQ-021 SHALL compute x2 = x_in*x_in (32-bit unsigned) in pipeline stage 1.
REQ-022 SHALL compute sum = b0 + b1*x + b2*x2 in 52-bit signed arithmetic, x zero-extended, no intermediate truncation.
REQ-023 SHALL form fit = sum >>> FRAC (arithmetic shift).
REQ-024 SHALL set exercise = (ex_in != 0) && ({0,ex_in} > fit), signed compare on full fit width.
REQ-025 SHALL set value_out = exercise ? ex_in : cf_in.
REQ-026 SHALL set fit_out = fit saturated to [-2^23, 2^23-1].
REQ-027 SHALL present a sample accepted in cycle t with out_valid=1 in cycle t+2 when out_ready stays high.
REQ-028 SHALL freeze the whole pipeline while out_valid && !out_ready; no loss, duplication or reordering.
REQ-029 SHALL sustain one sample per cycle when out_ready is held high.
REQ-030 SHALL increment out_cnt on each out_valid && out_ready.
REQ-031 SHALL increment ex_count on each handshake that has exercise=1.
REQ-032 SHALL drive busy = (state==RUN || state==DRAIN).
REQ-033 SHALL hold ex_count and the last output fields in DONE_ST until the next start.

Reset
REQ-034 SHALL, on rst=1 at a clock edge in any state including mid-pass:
- go to IDLE;
- clear all counters, coefficients and pipeline valid bits;
- drive out_valid, in_ready, done, busy, exercise to 0 and fit_out, value_out, ex_count to 0.
REQ-035 SHALL give rst priority over start in the same cycle.

Structure
REQ-036 SHALL place N_PATHS, FRAC, the data widths and the state encoding in shared package opt_pkg.
REQ-037 SHALL isolate the 2-stage stallable polynomial datapath (REQ-021 to REQ-026) in sub-module poly_eval_pipe.
REQ-038 SHALL keep control, counters and handshake in cont_eval.

Verification
REQ-039 SHALL cover: b0=25600, b1=b2=0; x=5, ex=150, cf=90 -> fit_out=100, exercise=1, value_out=150, two cycles after accept.
REQ-040 SHALL cover: b0=0, b1=0, b2=256; x=10, ex=99, cf=120 -> fit=100, exercise=0, value_out=120.
REQ-041 SHALL cover ex=0 and b0=-2560 (fit=-10): x=1, ex=0, cf=7 -> exercise=0, value_out=7.
REQ-042 SHALL cover b2=131071, x=65535 -> fit_out saturates to 8388607.
REQ-043 SHALL cover N_PATHS=4, random out_ready stalls -> 4 ordered outputs, done pulses once, ex_count correct.
REQ-044 SHALL cover rst asserted after 2 accepted samples -> next cycle IDLE, all outputs 0; a following start runs a clean full pass.
